// File: rtl/cell_lib_pkg.sv
// cell_lib_pkg: shared constants for the clocked-logic cell library
package cell_lib_pkg;
    localparam int MAX_LATENCY   = 8;
    localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/basic_and_cell_pipe_reg.sv
// pipe_reg: WIDTH-bit register with synchronous active-high clear
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // clear has priority over loading new data
    always_ff @(posedge clk)
        q <= rst ? '0 : d;
endmodule

// File: rtl/basic_and_cell.sv
// basic_and_cell: registered bitwise AND with a LATENCY-deep pipeline
module basic_and_cell
    import cell_lib_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    output logic [WIDTH-1:0] out,
    input  logic             rst
);
    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("basic_and_cell: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("basic_and_cell: WIDTH %0d must be at least 1", WIDTH);
    end

    // node[0] is the unregistered AND; node[i+1] is the output of register stage i
    logic [WIDTH-1:0] node [LATENCY+1];

    assign node[0] = a & b;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        pipe_reg #(.WIDTH(WIDTH)) u_reg (
            .clk (clk),
            .rst (rst),
            .d   (node[i]),
            .q   (node[i+1])
        );
    end

    assign out = node[LATENCY];
endmodule

// File: tb/tb_basic_and_cell.sv
// tb_basic_and_cell: randomized and directed checks of basic_and_cell at two configurations
module tb_basic_and_cell;
    logic       clk;
    logic       a1, b1, rst1, out1;
    logic [3:0] a3, b3, out3;
    logic       rst3;
    int total = 0;
    int bad = 0;

    basic_and_cell dut1 (.a(a1), .b(b1), .clk(clk), .out(out1), .rst(rst1));
    basic_and_cell #(.WIDTH(4), .LATENCY(3)) dut3 (.a(a3), .b(b3), .clk(clk), .out(out3), .rst(rst3));

    // first rising edge at t=50, then every 40
    initial begin
        clk = 0;
        #50;
        forever begin
            clk = 1; #20;
            clk = 0; #20;
        end
    end

    // reference model: per-edge sample history plus edges elapsed since last reset
    logic       hv1 [$];
    logic [3:0] hv3 [$];
    int since1 = 100;
    int since3 = 100;

    always @(posedge clk) begin
        hv1.push_back(a1 & b1);
        hv3.push_back(a3 & b3);
        if (hv1.size() > 8) void'(hv1.pop_front());
        if (hv3.size() > 8) void'(hv3.pop_front());
        since1 = rst1 ? 0 : since1 + 1;
        since3 = rst3 ? 0 : since3 + 1;
    end

    // a sample reaches out L-1 edges after its own edge unless a reset edge lies in that window
    function automatic logic [3:0] exp1();
        return (since1 < 1) ? 4'd0 : {3'd0, hv1[hv1.size()-1]};
    endfunction

    function automatic logic [3:0] exp3();
        return (since3 < 3) ? 4'd0 : hv3[hv3.size()-3];
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_o1"}, {3'd0, out1}, exp1());
        check({tag, "_o3"}, out3, exp3());
    endtask

    initial begin
        a1 = 0; b1 = 0; rst1 = 0;
        a3 = 0; b3 = 0; rst3 = 1;
        // toggles between edges must not matter
        #20 a1 = 1;
        #10 a1 = 0;
        #10 b1 = 1;
        @(posedge clk);
        #1;
        check("toggle_edge", {3'd0, out1}, 4'd0);
        #9  b1 = 0;
        #10 a1 = 1;
        #10 check("toggle_hold", {3'd0, out1}, 4'd0);
        // reset held two edges with inputs high
        rst1 = 1; a1 = 1; b1 = 1;
        rst3 = 1; a3 = 4'hf; b3 = 4'hf;
        step("rst_a");
        check("rst_a_out1", {3'd0, out1}, 4'd0);
        step("rst_b");
        check("rst_b_out3", out3, 4'd0);
        rst1 = 0; rst3 = 0;
        step("rel_1");
        check("rel_1_out1", {3'd0, out1}, 4'd1);
        check("rel_1_out3", out3, 4'd0);
        step("rel_2");
        check("rel_2_out3", out3, 4'd0);
        step("rel_3");
        check("rel_3_out3", out3, 4'hf);
        // truth table on the default cell
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = i[1:0];
            step("tt");
            check($sformatf("tt_%0d", i), {3'd0, out1}, (i == 3) ? 4'd1 : 4'd0);
        end
        // single-cycle pulse through three stages
        a3 = 0; b3 = 0;
        repeat (3) step("lat_flush");
        a3 = 4'b1100; b3 = 4'b1010;
        step("lat_0");
        a3 = 0; b3 = 0;
        check("lat_e1", out3, 4'd0);
        step("lat_1");
        check("lat_e2", out3, 4'd0);
        step("lat_2");
        check("lat_e3", out3, 4'b1000);
        step("lat_3");
        check("lat_e4", out3, 4'd0);
        // reset pulse with a full pipeline
        a3 = 4'hf; b3 = 4'hf;
        repeat (3) step("mid_fill");
        rst3 = 1;
        step("mid_r");
        check("mid_r_out3", out3, 4'd0);
        rst3 = 0;
        step("mid_1");
        check("mid_1_out3", out3, 4'd0);
        step("mid_2");
        check("mid_2_out3", out3, 4'd0);
        step("mid_3");
        check("mid_3_out3", out3, 4'hf);
        // reset wins over data on the same edge
        rst1 = 1; a1 = 1; b1 = 1;
        step("sim");
        check("sim_out1", {3'd0, out1}, 4'd0);
        rst1 = 0;
        // random traffic with occasional resets
        for (int i = 0; i < 200; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a3 = 4'($urandom); b3 = 4'($urandom);
            rst1 = ($urandom_range(15) == 0);
            rst3 = ($urandom_range(15) == 0);
            step("rnd");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
